// File: rtl/power_emu_host_ctrl.sv
// rtl/power_emu_host_ctrl.sv - register-bus initiator for the power-emulator slave register file
// Optional run cycle counter enabled by defining PEMU_HOST_CYCCNT_EN.
module power_emu_host_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [15:0] run_cycles,
  output logic        busy,
  output logic        m_read,
  output logic        m_write,
  output logic [3:0]  m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] res_out,
  output logic [35:0] vs_out,
  output logic [35:0] vc_out,
  output logic [31:0] cyc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_START, S_RUN, S_WR_FIN, S_RD_REQ, S_RD_WAIT, S_WR_CLR, S_DONE
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_k;
  logic [1:0]  r_lat;

  // Strobe/address/data registers are loaded for the state being entered, so
  // every bus output is registered and returns to zero outside strobe cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_k       <= '0;
      r_lat     <= '0;
      busy      <= 1'b0;
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      out_valid <= 1'b0;
      res_out   <= '0;
      vs_out    <= '0;
      vc_out    <= '0;
    end else begin
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            r_state <= S_WR_START;
            r_cnt   <= run_cycles;
            r_k     <= '0;
            busy    <= 1'b1;
            m_write <= 1'b1;
            m_wdata <= 32'h1;
          end
        end
        S_WR_START: begin
          if (r_cnt == 16'd0) begin
            r_state <= S_WR_FIN;
            m_write <= 1'b1;
            m_wdata <= 32'h2;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            r_state <= S_WR_FIN;
            m_write <= 1'b1;
            m_wdata <= 32'h2;
          end
        end
        S_WR_FIN: begin
          r_state <= S_RD_REQ;
          m_read  <= 1'b1;
          m_addr  <= 4'd1;
        end
        S_RD_REQ: begin
          r_state <= S_RD_WAIT;
          r_lat   <= '0;
        end
        S_RD_WAIT: begin
          if (r_lat == LAT_LAST) begin
            case (r_k)
              3'd0:    res_out[31:0]  <= m_rdata;
              3'd1:    res_out[35:32] <= m_rdata[3:0];
              3'd2:    vs_out[31:0]   <= m_rdata;
              3'd3:    vs_out[35:32]  <= m_rdata[3:0];
              3'd4:    vc_out[31:0]   <= m_rdata;
              default: vc_out[35:32]  <= m_rdata[3:0];
            endcase
            if (r_k != 3'd5) begin
              r_k     <= r_k + 3'd1;
              r_state <= S_RD_REQ;
              m_read  <= 1'b1;
              m_addr  <= {1'b0, r_k} + 4'd2;
            end else begin
              r_state <= S_WR_CLR;
              m_write <= 1'b1;
            end
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_WR_CLR: begin
          r_state   <= S_DONE;
          out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PEMU_HOST_CYCCNT_EN
  logic [31:0] r_cyc;

  // Counts WR_START through WR_CLR; holds in DONE and IDLE until re-armed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc <= '0;
    end else if (r_state == S_IDLE && cmd_start) begin
      r_cyc <= '0;
    end else if (r_state != S_IDLE && r_state != S_DONE && r_cyc != 32'hFFFF_FFFF) begin
      r_cyc <= r_cyc + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc;
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_power_emu_host_ctrl.sv
// tb/tb_power_emu_host_ctrl.sv - scoreboard bench for power_emu_host_ctrl at RD_LAT 1 and 3
module tb_power_emu_host_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] run_cycles;
  logic        cmd_start [2];
  logic        out_ready [2];
  logic        busy      [2];
  logic        m_read    [2];
  logic        m_write   [2];
  logic        out_valid [2];
  logic [3:0]  m_addr    [2];
  logic [31:0] m_wdata   [2];
  logic [31:0] m_rdata   [2];
  logic [31:0] cyc_cnt   [2];
  logic [35:0] res_out   [2];
  logic [35:0] vs_out    [2];
  logic [35:0] vc_out    [2];

  logic [31:0]  mem [1:6];
  logic [31:0]  words [6];
  logic [36:0]  exp_bus [$];
  logic [107:0] exp_res [$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [107:0] obs, input logic [107:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] pipe [LAT];

    power_emu_host_ctrl #(.RD_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start[g]), .run_cycles(run_cycles),
      .busy(busy[g]), .m_read(m_read[g]), .m_write(m_write[g]), .m_addr(m_addr[g]),
      .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g]), .out_valid(out_valid[g]),
      .out_ready(out_ready[g]), .res_out(res_out[g]), .vs_out(vs_out[g]),
      .vc_out(vc_out[g]), .cyc_cnt(cyc_cnt[g])
    );

    // Slave read pipeline: data appears exactly LAT cycles after the read strobe.
    always @(posedge clk) begin
      pipe[0] <= (m_read[g] && m_addr[g] >= 4'd1 && m_addr[g] <= 4'd6) ? mem[m_addr[g]] : 32'hBAD0_BAD0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata[g] = pipe[LAT-1];

    always @(negedge clk) begin
      if (!reset && (m_read[g] || m_write[g])) begin
        check("bus_excl", 108'(m_read[g] && m_write[g]), 108'd0);
        if (exp_bus.size() == 0)
          check($sformatf("bus_extra%0d", g), {m_write[g], m_addr[g], m_wdata[g]}, 108'd0);
        else
          check($sformatf("bus%0d", g), {m_write[g], m_addr[g], m_wdata[g]}, exp_bus.pop_front());
      end
    end
  end

  task automatic run_one(input int g, input logic [15:0] rc, input int hold, input bit pulse);
    int lat;
    int n;
    int exp_lat;
    logic [107:0] e;
    logic [107:0] held;
    lat = (g == 0) ? 1 : 3;
    exp_lat = int'(rc) + 3 + 6 * (1 + lat);
    for (int i = 0; i < 6; i++) mem[i+1] = words[i];
    exp_bus.push_back({1'b1, 4'd0, 32'h1});
    exp_bus.push_back({1'b1, 4'd0, 32'h2});
    for (int k = 0; k < 6; k++) exp_bus.push_back({1'b0, 4'(k + 1), 32'h0});
    exp_bus.push_back({1'b1, 4'd0, 32'h0});
    exp_res.push_back({words[5][3:0], words[4], words[3][3:0], words[2], words[1][3:0], words[0]});
    out_ready[g] = (hold == 0);
    run_cycles = rc;
    cmd_start[g] = 1'b1;
    @(negedge clk);
    cmd_start[g] = 1'b0;
    check("start_busy", 108'(busy[g]), 108'd1);
    n = 0;
    while (!out_valid[g] && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("latency", 108'(n), 108'(exp_lat));
    e = exp_res.pop_front();
    held = {vc_out[g], vs_out[g], res_out[g]};
    check("result", held, e);
`ifdef PEMU_HOST_CYCCNT_EN
    check("cyc_cnt", 108'(cyc_cnt[g]), 108'(exp_lat));
`else
    check("cyc_cnt", 108'(cyc_cnt[g]), 108'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 3) cmd_start[g] = 1'b1;
      @(negedge clk);
      cmd_start[g] = 1'b0;
      check("hold_valid", 108'(out_valid[g]), 108'd1);
      check("hold_busy", 108'(busy[g]), 108'd1);
      check("hold_data", {vc_out[g], vs_out[g], res_out[g]}, held);
    end
    out_ready[g] = 1'b1;
    cmd_start[g] = pulse;
    @(negedge clk);
    cmd_start[g] = 1'b0;
    out_ready[g] = 1'b0;
    check("post_valid", 108'(out_valid[g]), 108'd0);
    check("post_busy", 108'(busy[g]), 108'd0);
    check("post_data", {vc_out[g], vs_out[g], res_out[g]}, held);
    repeat (4) @(negedge clk);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 6; i++) words[i] = $urandom;
  endtask

  initial begin
    reset = 1'b1;
    run_cycles = '0;
    for (int g = 0; g < 2; g++) begin
      cmd_start[g] = 1'b0;
      out_ready[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++)
      check("reset_state", {busy[g], m_read[g], m_write[g], m_addr[g], m_wdata[g], out_valid[g],
                            res_out[g], vs_out[g], cyc_cnt[g]}, 108'd0);
    reset = 1'b0;
    @(negedge clk);

    words[0] = 32'hDEADBEEF; words[1] = 32'hFFFFFFF5; words[2] = 32'h12345678;
    words[3] = 32'h3;        words[4] = 32'h0;        words[5] = 32'hA;
    run_one(0, 16'd3, 0, 1'b0);
    check("basic_res", 108'(res_out[0]), 108'h5DEADBEEF);
    check("basic_vs", 108'(vs_out[0]), 108'h312345678);
    check("basic_vc", 108'(vc_out[0]), 108'hA00000000);

    rand_words();
    run_one(0, 16'd0, 10, 1'b1);
    rand_words();
    run_one(1, 16'd5, 0, 1'b0);
    rand_words();
    run_one(1, 16'd0, 2, 1'b1);

    rand_words();
    for (int i = 0; i < 6; i++) mem[i+1] = words[i];
    exp_bus.push_back({1'b1, 4'd0, 32'h1});
    run_cycles = 16'd100;
    cmd_start[0] = 1'b1;
    @(negedge clk);
    cmd_start[0] = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun_reset", {busy[0], m_read[0], m_write[0], m_addr[0], m_wdata[0], out_valid[0],
                           res_out[0], vs_out[0], cyc_cnt[0]}, 108'd0);
    check("midrun_vc", 108'(vc_out[0]), 108'd0);
    repeat (120) @(negedge clk);

    rand_words();
    run_one(0, 16'd7, 1, 1'b0);

    check("bus_left", 108'(exp_bus.size()), 108'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/power_emu_host_ctrl.md
# power_emu_host_ctrl

Register-bus initiator that drives the power-emulator slave register file: writes the CTRL word (address 0) to start and finish an emulation run, then reads back the six result/vs/vc words (addresses 1–6). It reassembles them into three 36-bit values and presents them on a valid/ready output. It sits between a local sequencer or test harness and the emulator's `s_*` slave port.

## Interface
- `RD_LAT`, 1, slave read latency in cycles: `m_rdata` is valid `RD_LAT` cycles after the `m_read` cycle (range 1–4).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_start`  in  1  one-cycle request to begin a run; accepted only in IDLE.
- `run_cycles`  in  16  number of RUN wait cycles; sampled when `cmd_start` is accepted.
- `busy`  out  1  high from the cycle after acceptance until the return to IDLE.
- `m_read`  out  1  slave read strobe.
- `m_write`  out  1  slave write strobe.
- `m_addr`  out  4  slave word address.
- `m_wdata`  out  32  slave write data.
- `m_rdata`  in  32  slave read data.
- `out_valid`  out  1  result set available.
- `out_ready`  in  1  consumer accepts the result set.
- `res_out`, `vs_out`, `vc_out`  out  36 each  assembled emulator result, vs and vc.
- `cyc_cnt`  out  32  run cycle count (see Configuration).

## Operation
- States: IDLE, WR_START, RUN, WR_FIN, RD_REQ, RD_WAIT, WR_CLR, DONE.
- IDLE, with `cmd_start`=1: latch `run_cycles`, clear read index k to 0, go to WR_START.
- WR_START: `m_write`=1, `m_addr`=0, `m_wdata`=0x1 (start bit). Next state is RUN, or WR_FIN if the latched count is 0.
- RUN: decrement the latched count each cycle. Leave for WR_FIN in the cycle the count reaches 1, so RUN lasts exactly `run_cycles` cycles.
- WR_FIN: `m_write`=1, `m_addr`=0, `m_wdata`=0x2 (fin bit). Go to RD_REQ.
- RD_REQ: `m_read`=1, `m_addr`=k+1. Go to RD_WAIT.
- RD_WAIT: wait `RD_LAT` cycles. On the last cycle, capture `m_rdata` into word k.
  - If k<5: increment k and go to RD_REQ.
  - Otherwise go to WR_CLR.
- WR_CLR: `m_write`=1, `m_addr`=0, `m_wdata`=0x0. Go to DONE.
- DONE: `out_valid`=1. On `out_valid`&&`out_ready`, go to IDLE.
- Assembly:
  - `res_out` = {w1[3:0], w0}
  - `vs_out` = {w3[3:0], w2}
  - `vc_out` = {w5[3:0], w4}
  - Upper 28 bits of the odd words are discarded.
- `m_read` and `m_write` are never high together. `m_addr`/`m_wdata` are 0 whenever no strobe is high.
- Output data registers hold their value after the handshake and update only on the next run's captures.

## Timing
- Reset values: all outputs 0, state IDLE, k=0.
- All outputs are registered. `cmd_start` accepted at edge T gives `m_write` high in cycle T+1.
- Total run, from WR_START to the first DONE cycle: 1 + `run_cycles` + 1 + 6·(1+`RD_LAT`) + 1 cycles.
  - With `RD_LAT`=1 this is `run_cycles`+15.
- `out_ready` may be high before or with the first `out_valid` cycle. The handshake then completes in that cycle and the block is in IDLE on the next cycle.
- `cmd_start` is ignored while `busy` or in DONE, including the handshake cycle. It is accepted again from IDLE on the following cycle.
- `reset` mid-run: immediate return to IDLE with the reset values. No clearing write is issued, so the slave CTRL word may remain 0x1 or 0x2. The software or sequencer must rerun to clear it.
- `run_cycles`=0xFFFF is legal: RUN lasts 65535 cycles.

## Configuration
- `PEMU_HOST_CYCCNT_EN` defined:
  - A 32-bit counter clears on acceptance and increments every cycle from WR_START through WR_CLR inclusive.
  - It saturates at 0xFFFFFFFF.
  - `cyc_cnt` shows the final value from DONE until the next acceptance.
- `PEMU_HOST_CYCCNT_EN` not defined: no counter logic; `cyc_cnt` is tied to 0.

## Test plan
- Basic run: `RD_LAT`=1, `run_cycles`=3, slave model preloaded with w0..w5 = 0xDEADBEEF, 0xFFFFFFF5, 0x12345678, 0x3, 0x0, 0xA.
  - Required bus sequence: write(0,0x1), write(0,0x2), reads of addresses 1..6, write(0,0x0).
  - `res_out`=0x5DEADBEEF, `vs_out`=0x312345678, `vc_out`=0xA00000000.
  - `out_valid` first high 18 cycles after the WR_START cycle.
- Zero run length: `run_cycles`=0. WR_FIN immediately follows WR_START, and the run totals 15 cycles.
- Backpressure: `out_ready` held at 0 for 10 cycles. `out_valid` and the data stay stable and `busy`=1. `cmd_start` pulsed during this window is ignored (no bus activity).
- Read latency: `RD_LAT`=3 against a 3-cycle slave model. All six words are captured correctly and the run totals `run_cycles`+27.
- Reset mid-RUN: assert `reset` during RUN with `run_cycles`=100.
  - All outputs are 0 the next cycle and no further strobes appear.
  - A new `cmd_start` then completes normally.
- Counter: with `PEMU_HOST_CYCCNT_EN` and `run_cycles`=3, `cyc_cnt`=18 in DONE. Without the macro, `cyc_cnt`=0 throughout.
